// File: rtl/mc_main_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32 main controller: opcodes, states,
// datapath select codes and the control bundle driven by the FSM.
package mc_main_fsm_pkg;

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R_TYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I_TYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Shared with the ALU-control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/mc_mem_watchdog.sv
// Counts stalled memory-request cycles; flags when the next stall must trap.
module mc_mem_watchdog #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  input  logic clr_i,
  output logic at_limit_c
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A state change always restarts the count, even on the cycle that stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (mem_req_i && !mem_ready_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_c = (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/mc_main_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects from the current state.
module mc_main_fsm
  import mc_main_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned STATE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         result_src,
  output logic               fault,
  output logic [STATE_W-1:0] state_dbg
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   fault_q, fault_d;
  logic   wait_at_limit;

  mc_mem_watchdog #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_watchdog (
    .clk_i      (clk),
    .rst_i      (reset),
    .mem_req_i  (ctrl.mem_req),
    .mem_ready_i(mem_ready),
    .clr_i      (state_d != state_q),
    .at_limit_c (wait_at_limit)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (wait_at_limit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        // Unknown or X opcodes land in the default arm and trap.
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R_TYPE:         state_d = S_EXECR;
          OP_I_TYPE:         state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        if (op == OP_LOAD) begin
          state_d = S_MEMREAD;
        end else if (op == OP_STORE) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (wait_at_limit) begin
          state_d = S_TRAP;
        end
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wait_at_limit) begin
          state_d = S_TRAP;
        end
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
        state_d         = S_FETCH;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        state_d         = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  assign fault_d = fault_q | (state_d == S_TRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Write strobes are masked by reset so FETCH's mem_ready path cannot fire under reset.
  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we    & ~reset;
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write  & ~reset;
  assign pc_write   = ctrl.pc_write  & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign fault      = fault_q;
  assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm: the driver queues the expected output vector
// for each cycle it drives, the monitor pops and compares mid-cycle.
module tb_mc_main_fsm;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;
  localparam int         WAIT_MAX  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, fault;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state_dbg;
  logic [18:0] act;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  mc_main_fsm #(.MEM_WAIT_MAX(WAIT_MAX), .STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .adr_src   (adr_src),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .result_src(result_src),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  assign act = {state_dbg, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, fault};

  // Output table per state, written out from the controller's output list.
  function automatic logic [18:0] expv(input logic [3:0] s, input logic rdy,
                                       input logic z, input logic rst);
    logic       mreq, mwe, adr, irw, pcw, rw, f;
    logic [1:0] a, b, ao, rs;
    mreq = 1'b0; mwe = 1'b0; adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; f = 1'b0;
    a = 2'b00; b = 2'b00; ao = 2'b00; rs = 2'b00;
    case (s)
      4'd0:  begin mreq = 1'b1; b = 2'b10; rs = 2'b10; irw = rdy & ~rst; pcw = rdy & ~rst; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin mreq = 1'b1; adr = 1'b1; end
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin mreq = 1'b1; mwe = 1'b1; adr = 1'b1; end
      4'd6:  begin a = 2'b10; b = 2'b00; ao = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      4'd8:  begin rw = 1'b1; end
      4'd9:  begin a = 2'b10; ao = 2'b01; pcw = z; end
      4'd10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      4'd15: begin f = 1'b1; end
      default: ;
    endcase
    return {s, mreq, mwe, adr, irw, pcw, rw, a, b, ao, rs, f};
  endfunction

  // Called at posedge+1: drive this cycle's inputs, queue its expectation.
  task automatic step(input string tag, input logic rdy, input logic z, input logic [3:0] s);
    exp_t e;
    mem_ready = rdy;
    zero      = z;
    e.tag     = tag;
    e.v       = expv(s, rdy, z, 1'b0);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle with mem_ready high and checks the outputs straight away.
  task automatic do_reset(input string tag);
    exp_t e;
    #1;
    mem_ready = 1'b1;
    e.tag     = tag;
    e.v       = expv(4'd0, 1'b1, 1'b0, 1'b1);
    sb.push_back(e);
    reset = 1'b1;
    #1;
    ->chk_ev;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got state/ctrl %b, expected %b", e.tag, act, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : driver
    @(posedge clk);
    #1;
    do_reset("reset_hold");

    op = OP_R_TYPE;
    step("add", 1'b1, 1'b0, 4'd0);
    step("add", 1'b0, 1'b0, 4'd1);
    step("add", 1'b0, 1'b0, 4'd6);
    step("add", 1'b0, 1'b0, 4'd8);

    op = OP_LOAD;
    for (int i = 0; i < 3; i++) step("lw", 1'b0, 1'b0, 4'd0);
    step("lw", 1'b1, 1'b0, 4'd0);
    step("lw", 1'b0, 1'b0, 4'd1);
    step("lw", 1'b0, 1'b0, 4'd2);
    step("lw", 1'b0, 1'b0, 4'd3);
    step("lw", 1'b0, 1'b0, 4'd3);
    step("lw", 1'b1, 1'b0, 4'd3);
    step("lw", 1'b0, 1'b0, 4'd4);

    op = OP_BRANCH;
    step("beq_taken", 1'b1, 1'b1, 4'd0);
    step("beq_taken", 1'b0, 1'b1, 4'd1);
    step("beq_taken", 1'b0, 1'b1, 4'd9);
    step("beq_not", 1'b1, 1'b0, 4'd0);
    step("beq_not", 1'b0, 1'b0, 4'd1);
    step("beq_not", 1'b0, 1'b0, 4'd9);

    op = OP_STORE;
    step("sw", 1'b1, 1'b0, 4'd0);
    step("sw", 1'b0, 1'b0, 4'd1);
    step("sw", 1'b0, 1'b0, 4'd2);
    step("sw", 1'b0, 1'b0, 4'd5);
    step("sw", 1'b1, 1'b0, 4'd5);

    op = OP_I_TYPE;
    step("addi", 1'b1, 1'b0, 4'd0);
    step("addi", 1'b0, 1'b0, 4'd1);
    step("addi", 1'b0, 1'b0, 4'd7);
    step("addi", 1'b0, 1'b0, 4'd8);

    op = OP_JAL;
    step("jal", 1'b1, 1'b0, 4'd0);
    step("jal", 1'b0, 1'b0, 4'd1);
    step("jal", 1'b0, 1'b0, 4'd10);
    step("jal", 1'b0, 1'b0, 4'd8);

    op = OP_BAD;
    step("bad_op", 1'b1, 1'b0, 4'd0);
    step("bad_op", 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 20; i++) step("bad_op_trap", 1'b1, 1'b1, 4'd15);
    do_reset("reset_after_trap");

    op = OP_R_TYPE;
    for (int i = 0; i < WAIT_MAX; i++) step("wd_wait", 1'b0, 1'b0, 4'd0);
    step("wd_trap", 1'b0, 1'b0, 4'd15);
    step("wd_trap", 1'b1, 1'b0, 4'd15);
    do_reset("reset_after_wd");

    for (int i = 0; i < WAIT_MAX - 1; i++) step("wd_edge_wait", 1'b0, 1'b0, 4'd0);
    step("wd_edge_ready", 1'b1, 1'b0, 4'd0);
    step("wd_edge", 1'b0, 1'b0, 4'd1);
    step("wd_edge", 1'b0, 1'b0, 4'd6);
    step("wd_edge", 1'b0, 1'b0, 4'd8);

    op = OP_STORE;
    step("sw_rst", 1'b1, 1'b0, 4'd0);
    step("sw_rst", 1'b0, 1'b0, 4'd1);
    step("sw_rst", 1'b0, 1'b0, 4'd2);
    step("sw_rst", 1'b0, 1'b0, 4'd5);
    step("sw_rst", 1'b0, 1'b0, 4'd5);
    do_reset("reset_mid_memwrite");
    step("post_reset", 1'b0, 1'b0, 4'd0);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
